// File: rtl/mem1_stage_pkg.sv
// mem1_stage_pkg: shared types for the first memory stage and its neighbours
// Contents:
//   byte_type_e          access size encoding shared with Execute and Mem2
//   mem1_fsm_e           D-cache request sequencer states
//   ECODE_ALE            address-misalignment exception code
//   execute_mem1_pass_t  Execute -> Mem1 pipeline payload
//   excp_pass_t          in-flight exception record
//   forward_req_t        forwarding source published back to Execute
//   mem1_mem2_pass_t     Mem1 -> Mem2 payload (Execute payload + req_sent)
package mem1_stage_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } byte_type_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SENT
    } mem1_fsm_e;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic [31:0] rkd;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic        is_mem;
        logic        is_store;
        byte_type_e  byte_type;
        logic        is_flush;
    } execute_mem1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } forward_req_t;

    // is_flush inside ex carries the Mem1 kill decision downstream
    typedef struct packed {
        execute_mem1_pass_t ex;
        logic               req_sent;
    } mem1_mem2_pass_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement and alignment check for a memory access
// Ports:
//   byte_type   in   access size (BYTE/HALF/WORD)
//   addr_lo     in   address bits [1:0]
//   rkd         in   store data, right-justified
//   wstrb       out  byte enables (also used as the load read mask)
//   wdata       out  store data replicated onto every candidate lane
//   misaligned  out  half not on 2-byte or word not on 4-byte boundary
module mem_lane_align
    import mem1_stage_pkg::*;
(
    input  byte_type_e  byte_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rkd,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Replicating the data means the cache only has to honour wstrb
    always_comb begin
        wstrb      = byte_type == WORD ? 4'b1111 : (byte_type == HALF ? 4'b0011 : 4'b0001) << addr_lo;
        wdata      = byte_type == WORD ? rkd : byte_type == HALF ? {2{rkd[15:0]}} : {4{rkd[7:0]}};
        misaligned = byte_type == WORD ? |addr_lo : byte_type == HALF ? addr_lo[0] : 1'b0;
    end

endmodule

// File: rtl/mem1_stage.sv
// mem1_stage: first memory stage, issues D-cache requests and checks alignment
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   is_stall         hold the pipeline register
//   is_flush         kill the instruction currently in this stage
//   pass_in          Execute payload
//   excp_pass_in     exception record from Execute
//   mem1_req         forwarding source back to Execute
//   mem1_stall       request presented but not yet accepted
//   dc_req_valid/dc_req_ready  D-cache request handshake
//   dc_addr, dc_is_store, dc_wstrb, dc_wdata  D-cache request payload
//   pass_out         payload to Mem2 (kill folded into is_flush, plus req_sent)
//   excp_pass_out    exception record to Mem2, including ALE
module mem1_stage
    import mem1_stage_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1,
    parameter int ADDR_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               is_stall,
    input  logic               is_flush,
    input  execute_mem1_pass_t pass_in,
    input  excp_pass_t         excp_pass_in,
    output forward_req_t       mem1_req,
    output logic               mem1_stall,
    output logic               dc_req_valid,
    input  logic               dc_req_ready,
    output logic [ADDR_W-1:0]  dc_addr,
    output logic               dc_is_store,
    output logic [3:0]         dc_wstrb,
    output logic [31:0]        dc_wdata,
    output mem1_mem2_pass_t    pass_out,
    output excp_pass_t         excp_pass_out
);

    execute_mem1_pass_t pass_in_r;
    excp_pass_t         excp_pass_in_r;
    mem1_fsm_e          state, state_nxt;
    logic               lane_mis, ale, kill, handshake;

    // Reset leaves a bubble in the register so nothing issues out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_in_r          <= '0;
            pass_in_r.is_flush <= 1'b1;
            excp_pass_in_r     <= '0;
            state              <= IDLE;
        end else begin
            if (!is_stall) begin
                pass_in_r      <= pass_in;
                excp_pass_in_r <= excp_pass_in;
            end
            state <= is_stall ? state_nxt : IDLE;
        end
    end

    mem_lane_align u_align (
        .byte_type (pass_in_r.byte_type),
        .addr_lo   (pass_in_r.ex_out[1:0]),
        .rkd       (pass_in_r.rkd),
        .wstrb     (dc_wstrb),
        .wdata     (dc_wdata),
        .misaligned(lane_mis)
    );

    assign ale         = ALIGN_CHECK & pass_in_r.is_mem & ~pass_in_r.is_flush & lane_mis;
    assign kill        = is_flush | pass_in_r.is_flush | excp_pass_in_r.valid | ale;
    assign dc_addr     = pass_in_r.ex_out[ADDR_W-1:0];
    assign dc_is_store = pass_in_r.is_store;
    assign handshake   = dc_req_valid & dc_req_ready;
    assign mem1_stall  = dc_req_valid & ~dc_req_ready;

    // Once in WAIT the request is committed: valid stays up until accepted,
    // and a flush only retires it on the following edge.
    always_comb begin
        dc_req_valid = state == WAIT | (state == IDLE & pass_in_r.is_mem & ~kill);
        state_nxt    = state == IDLE ? (dc_req_valid ? (dc_req_ready ? SENT : WAIT) : IDLE) :
                       state == WAIT ? (dc_req_ready ? SENT : kill ? IDLE : WAIT) : SENT;
    end

    always_comb begin
        mem1_req.valid = pass_in_r.is_wr_rd & ~pass_in_r.is_mem & ~kill & |pass_in_r.rd;
        mem1_req.idx   = pass_in_r.rd;
        mem1_req.data  = pass_in_r.is_wr_rd_pc_plus4 ? pass_in_r.pc_plus4 : pass_in_r.ex_out;
        excp_pass_out  = excp_pass_in_r;
        if (ale && !excp_pass_in_r.valid) begin
            excp_pass_out.valid = 1'b1;
            excp_pass_out.ecode = ECODE_ALE;
            excp_pass_out.badv  = pass_in_r.ex_out;
        end
        pass_out.ex          = pass_in_r;
        pass_out.ex.is_flush = kill;
        pass_out.req_sent    = state == SENT | handshake;
    end

endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: self-checking bench for mem1_stage against a size/offset reference model
module tb_mem1_stage;
    import mem1_stage_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n, is_stall, is_flush, dc_req_ready;
    execute_mem1_pass_t pass_in;
    excp_pass_t         excp_pass_in;
    forward_req_t       mem1_req;
    logic               mem1_stall, dc_req_valid, dc_is_store;
    logic [31:0]        dc_addr, dc_wdata;
    logic [3:0]         dc_wstrb;
    mem1_mem2_pass_t    pass_out;
    excp_pass_t         excp_pass_out;

    int checks = 0;
    int errors = 0;
    int hs     = 0;

    mem1_stage #(.ALIGN_CHECK(1'b1), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_stall     (is_stall),
        .is_flush     (is_flush),
        .pass_in      (pass_in),
        .excp_pass_in (excp_pass_in),
        .mem1_req     (mem1_req),
        .mem1_stall   (mem1_stall),
        .dc_req_valid (dc_req_valid),
        .dc_req_ready (dc_req_ready),
        .dc_addr      (dc_addr),
        .dc_is_store  (dc_is_store),
        .dc_wstrb     (dc_wstrb),
        .dc_wdata     (dc_wdata),
        .pass_out     (pass_out),
        .excp_pass_out(excp_pass_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dc_req_valid && dc_req_ready) hs++;

    function automatic execute_mem1_pass_t bubble();
        execute_mem1_pass_t p = '0;
        p.is_flush = 1'b1;
        return p;
    endfunction

    function automatic execute_mem1_pass_t mem_op(input logic st, input byte_type_e bt,
                                                  input logic [31:0] addr, input logic [31:0] rkd);
        execute_mem1_pass_t p = '0;
        p.is_mem    = 1'b1;
        p.is_store  = st;
        p.byte_type = bt;
        p.ex_out    = addr;
        p.rkd       = rkd;
        p.rd        = st ? 5'd0 : 5'd7;
        p.is_wr_rd  = ~st;
        p.pc_plus4  = 32'h1c00_0004;
        return p;
    endfunction

    function automatic int size_of(input byte_type_e bt);
        return bt == WORD ? 4 : bt == HALF ? 2 : 1;
    endfunction

    function automatic logic [3:0] model_strb(input byte_type_e bt, input logic [31:0] addr);
        int mask = (1 << size_of(bt)) - 1;
        int sh   = mask << (addr % 4);
        return sh[3:0];
    endfunction

    function automatic logic [31:0] model_data(input byte_type_e bt, input logic [31:0] rkd);
        return bt == WORD ? rkd : bt == HALF ? rkd[15:0] * 32'h0001_0001 : rkd[7:0] * 32'h0101_0101;
    endfunction

    task automatic load(input execute_mem1_pass_t p, input excp_pass_t e);
        @(negedge clk);
        pass_in      = p;
        excp_pass_in = e;
        is_stall     = 1'b0;
        is_flush     = 1'b0;
        @(posedge clk);
        #1;
        pass_in      = bubble();
        excp_pass_in = '0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        is_stall     = 1'b0;
        is_flush     = 1'b0;
        dc_req_ready = 1'b1;
        pass_in      = mem_op(1'b1, WORD, 32'h10, 32'h1234);
        excp_pass_in = '0;
        #22;
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", dc_req_valid); end
        checks++; if (mem1_req.valid !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b exp 0", mem1_req.valid); end
        checks++; if (mem1_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", mem1_stall); end
        checks++; if (pass_out.ex.is_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b exp 1", pass_out.ex.is_flush); end
        checks++; if (pass_out.req_sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b exp 0", pass_out.req_sent); end
        @(negedge clk);
        pass_in = bubble();
        rst_n   = 1'b1;
    endtask

    task automatic test_store_word();
        int h0 = hs;
        dc_req_ready = 1'b1;
        load(mem_op(1'b1, WORD, 32'h1000_0004, 32'hDEAD_BEEF), '0);
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b exp 1", dc_req_valid); end
        checks++; if (dc_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b exp 1111", dc_wstrb); end
        checks++; if (dc_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h exp deadbeef", dc_wdata); end
        checks++; if (dc_addr !== 32'h1000_0004) begin errors++; $display("FAIL sw_addr: got %h exp 10000004", dc_addr); end
        checks++; if (dc_is_store !== 1'b1) begin errors++; $display("FAIL sw_store: got %b exp 1", dc_is_store); end
        checks++; if (mem1_stall !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b exp 0", mem1_stall); end
        checks++; if (pass_out.req_sent !== 1'b1) begin errors++; $display("FAIL sw_sent: got %b exp 1", pass_out.req_sent); end
        @(posedge clk);
        #1;
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL sw_one_cycle: got %b exp 0", dc_req_valid); end
        checks++; if (hs - h0 !== 1) begin errors++; $display("FAIL sw_handshakes: got %0d exp 1", hs - h0); end
    endtask

    task automatic test_byte_store();
        load(mem_op(1'b1, BYTE, 32'h0000_2002, 32'h0000_00AB), '0);
        checks++; if (dc_wstrb !== 4'b0100) begin errors++; $display("FAIL sb_wstrb: got %b exp 0100", dc_wstrb); end
        checks++; if (dc_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h exp abababab", dc_wdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_half_ale();
        int h0 = hs;
        load(mem_op(1'b0, HALF, 32'h0000_1001, $urandom), '0);
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL ale_valid: got %b exp 0", dc_req_valid); end
        checks++; if (excp_pass_out.valid !== 1'b1 || excp_pass_out.ecode !== ECODE_ALE) begin errors++; $display("FAIL ale_excp: got %b/%h exp 1/%h", excp_pass_out.valid, excp_pass_out.ecode, ECODE_ALE); end
        checks++; if (excp_pass_out.badv !== 32'h0000_1001) begin errors++; $display("FAIL ale_badv: got %h exp 00001001", excp_pass_out.badv); end
        checks++; if (pass_out.ex.is_flush !== 1'b1) begin errors++; $display("FAIL ale_flush: got %b exp 1", pass_out.ex.is_flush); end
        @(posedge clk);
        #1;
        checks++; if (hs !== h0) begin errors++; $display("FAIL ale_no_hs: got %0d exp %0d", hs, h0); end
    endtask

    task automatic test_wait_ready();
        int h0 = hs;
        dc_req_ready = 1'b0;
        load(mem_op(1'b0, WORD, 32'h3000_0010, 32'h0), '0);
        is_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem1_stall !== 1'b1 || dc_req_valid !== 1'b1) begin errors++; $display("FAIL wait_stall%0d: got %b/%b exp 1/1", i, mem1_stall, dc_req_valid); end
            checks++; if (dc_addr !== 32'h3000_0010) begin errors++; $display("FAIL wait_addr%0d: got %h exp 30000010", i, dc_addr); end
            checks++; if (pass_out.req_sent !== 1'b0) begin errors++; $display("FAIL wait_sent%0d: got %b exp 0", i, pass_out.req_sent); end
            @(posedge clk);
            #1;
        end
        dc_req_ready = 1'b1;
        #1;
        checks++; if (mem1_stall !== 1'b0) begin errors++; $display("FAIL wait_release: got %b exp 0", mem1_stall); end
        checks++; if (pass_out.req_sent !== 1'b1) begin errors++; $display("FAIL wait_req_sent: got %b exp 1", pass_out.req_sent); end
        is_stall = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (hs - h0 !== 1) begin errors++; $display("FAIL wait_handshakes: got %0d exp 1", hs - h0); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL wait_after: got %b exp 0", dc_req_valid); end
    endtask

    task automatic test_flush_wait();
        int h0 = hs;
        dc_req_ready = 1'b0;
        load(mem_op(1'b1, WORD, 32'h4000_0000, $urandom), '0);
        is_stall = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL fw_valid_wait: got %b exp 1", dc_req_valid); end
        is_flush = 1'b1;
        is_stall = 1'b0;
        #1;
        checks++; if (pass_out.ex.is_flush !== 1'b1) begin errors++; $display("FAIL fw_pass_flush: got %b exp 1", pass_out.ex.is_flush); end
        checks++; if (pass_out.req_sent !== 1'b0) begin errors++; $display("FAIL fw_sent: got %b exp 0", pass_out.req_sent); end
        @(posedge clk);
        #1;
        is_flush = 1'b0;
        checks++; if (dc_req_valid !== 1'b0 || mem1_stall !== 1'b0) begin errors++; $display("FAIL fw_drop: got %b/%b exp 0/0", dc_req_valid, mem1_stall); end
        dc_req_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (hs !== h0) begin errors++; $display("FAIL fw_no_hs: got %0d exp %0d", hs, h0); end
    endtask

    task automatic test_flush_sent();
        int h0 = hs;
        dc_req_ready = 1'b1;
        load(mem_op(1'b0, WORD, 32'h5000_0008, 32'h0), '0);
        is_stall = 1'b1;
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL fs_issue: got %b exp 1", dc_req_valid); end
        @(posedge clk);
        #1;
        checks++; if (dc_req_valid !== 1'b0 || pass_out.req_sent !== 1'b1) begin errors++; $display("FAIL fs_sent: got %b/%b exp 0/1", dc_req_valid, pass_out.req_sent); end
        is_flush = 1'b1;
        #1;
        checks++; if (pass_out.ex.is_flush !== 1'b1 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL fs_flush: got %b/%b exp 1/0", pass_out.ex.is_flush, dc_req_valid); end
        @(posedge clk);
        #1;
        is_flush = 1'b0;
        #1;
        checks++; if (dc_req_valid !== 1'b0 || pass_out.req_sent !== 1'b1) begin errors++; $display("FAIL fs_no_reissue: got %b/%b exp 0/1", dc_req_valid, pass_out.req_sent); end
        is_stall = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (hs - h0 !== 1) begin errors++; $display("FAIL fs_handshakes: got %0d exp 1", hs - h0); end
    endtask

    task automatic test_forward();
        execute_mem1_pass_t p = '0;
        forward_req_t       exp_fwd;
        p.is_wr_rd = 1'b1;
        p.rd       = 5'd5;
        p.ex_out   = 32'h42;
        load(p, '0);
        checks++; if (mem1_req !== forward_req_t'({1'b1, 5'd5, 32'h42})) begin errors++; $display("FAIL fwd_alu: got %h exp 1/05/00000042", mem1_req); end
        dc_req_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            p                   = '0;
            p.is_mem            = ($urandom_range(0, 3) == 0);
            p.is_store          = p.is_mem & $urandom_range(0, 1);
            p.byte_type         = WORD;
            p.is_wr_rd          = $urandom_range(0, 3) != 0;
            p.is_wr_rd_pc_plus4 = $urandom_range(0, 1);
            p.rd                = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
            p.ex_out            = $urandom & 32'hFFFF_FFFC;
            p.pc_plus4          = $urandom;
            p.rkd               = $urandom;
            exp_fwd.valid = p.is_wr_rd && !p.is_mem && p.rd != 0;
            exp_fwd.idx   = p.rd;
            exp_fwd.data  = p.is_wr_rd_pc_plus4 ? p.pc_plus4 : p.ex_out;
            load(p, '0);
            checks++; if (mem1_req.valid !== exp_fwd.valid) begin errors++; $display("FAIL fwd_valid%0d: got %b exp %b", i, mem1_req.valid, exp_fwd.valid); end
            if (exp_fwd.valid) begin
                checks++; if (mem1_req !== exp_fwd) begin errors++; $display("FAIL fwd_data%0d: got %h exp %h", i, mem1_req, exp_fwd); end
            end
            checks++; if (dc_req_valid !== p.is_mem) begin errors++; $display("FAIL fwd_dcport%0d: got %b exp %b", i, dc_req_valid, p.is_mem); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_mem();
        int                 h0 = hs;
        int                 exp_hs = 0;
        execute_mem1_pass_t p;
        excp_pass_t         e, exp_e;
        byte_type_e         bt;
        logic               older, mis, issue;
        dc_req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bt      = byte_type_e'($urandom_range(0, 2));
            p       = mem_op(1'($urandom_range(0, 1)), bt, $urandom, $urandom);
            older   = ($urandom_range(0, 4) == 0);
            e.valid = older;
            e.ecode = 6'($urandom_range(0, 63));
            e.badv  = $urandom;
            mis     = (p.ex_out % size_of(bt)) != 0;
            issue   = !older && !mis;
            exp_e   = (!older && mis) ? excp_pass_t'({1'b1, ECODE_ALE, p.ex_out}) : e;
            exp_hs += issue;
            load(p, e);
            checks++; if (dc_req_valid !== issue) begin errors++; $display("FAIL rnd_valid%0d: got %b exp %b", i, dc_req_valid, issue); end
            if (issue) begin
                checks++; if (dc_wstrb !== model_strb(bt, p.ex_out)) begin errors++; $display("FAIL rnd_wstrb%0d: got %b exp %b", i, dc_wstrb, model_strb(bt, p.ex_out)); end
                checks++; if (dc_wdata !== model_data(bt, p.rkd)) begin errors++; $display("FAIL rnd_wdata%0d: got %h exp %h", i, dc_wdata, model_data(bt, p.rkd)); end
            end
            checks++; if (excp_pass_out !== exp_e) begin errors++; $display("FAIL rnd_excp%0d: got %h exp %h", i, excp_pass_out, exp_e); end
            checks++; if (pass_out.ex.is_flush !== !issue) begin errors++; $display("FAIL rnd_flush%0d: got %b exp %b", i, pass_out.ex.is_flush, !issue); end
            checks++; if (mem1_req.valid !== 1'b0) begin errors++; $display("FAIL rnd_no_fwd%0d: got %b exp 0", i, mem1_req.valid); end
        end
        @(posedge clk);
        #1;
        checks++; if (hs - h0 !== exp_hs) begin errors++; $display("FAIL rnd_handshakes: got %0d exp %0d", hs - h0, exp_hs); end
    endtask

    task automatic test_async_reset();
        dc_req_ready = 1'b0;
        load(mem_op(1'b0, WORD, 32'h6000_0000, 32'h0), '0);
        is_stall = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL ar_wait: got %b exp 1", dc_req_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (dc_req_valid !== 1'b0 || mem1_stall !== 1'b0) begin errors++; $display("FAIL ar_drop: got %b/%b exp 0/0", dc_req_valid, mem1_stall); end
        checks++; if (pass_out.ex.is_flush !== 1'b1) begin errors++; $display("FAIL ar_flush: got %b exp 1", pass_out.ex.is_flush); end
        @(negedge clk);
        rst_n    = 1'b1;
        is_stall = 1'b1;
        dc_req_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dc_req_valid !== 1'b0 || pass_out.req_sent !== 1'b0) begin errors++; $display("FAIL ar_idle: got %b/%b exp 0/0", dc_req_valid, pass_out.req_sent); end
        is_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_store();
        test_half_ale();
        test_wait_ready();
        test_flush_wait();
        test_flush_sent();
        test_forward();
        test_random_mem();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
